muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle RV32M multiply/divide unit that executes the eight M-extension operations the ALU control decodes (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) on operands of parametrised width. It sits beside the single-cycle ALU in the execute stage. The pipeline stalls on `busy` and captures `result` on the one-cycle `done` pulse. Division always runs as an iterative restoring sequence; multiplication is iterative or single-cycle depending on configuration.

## Interface
- XLEN, 32: operand and result width in bits, ≥ 4.
- CNT_W, $clog2(XLEN)+1: width of the iteration counter, derived from XLEN, not overridden.

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request: latch operands and func3 when `ready`=1
- func3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  XLEN  rs1 (multiplicand / dividend)
- op_b  in  XLEN  rs2 (multiplier / divisor)
- flush  in  1  abort in-flight operation (pipeline kill)
- ready  out  1  unit idle, will accept `start` this cycle
- busy  out  1  operation in flight; equals ~ready
- done  out  1  one-cycle pulse, `result` valid
- result  out  XLEN  result; holds last value until next `done`

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: ready=1.
  - start=1 latches func3, the operand signs and the operand magnitudes. Signed operands are negated when negative. For MULHSU only op_a is treated as signed.
  - Special cases go straight to DONE with the result precomputed:
    - divisor 0: DIV and DIVU return all-ones, REM and REMU return op_a.
    - signed overflow (op_a = −2^(XLEN−1), op_b = −1): DIV returns op_a, REM returns 0.
  - All other operations go to CALC with counter = XLEN.
- CALC: one iteration per cycle; the counter decrements and reaching 0 moves the FSM to FIX.
  - Multiply: radix-2 shift-add into a 2·XLEN accumulator.
  - Divide: restoring shift-subtract producing a quotient and a remainder.
- FIX: sign correction, then DONE.
  - Product is negated if the operand signs differ (signed forms only).
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Result selection: MUL = product[XLEN−1:0]; MULH/MULHSU/MULHU = product[2·XLEN−1:XLEN]; DIV/DIVU = quotient; REM/REMU = remainder.
- DONE: done=1 and result is updated; the FSM returns to IDLE on the next edge.
- start while busy: ignored, with no queueing.
- flush: any state goes to IDLE on the next edge with no done pulse, and result is left unchanged. flush and start in the same IDLE cycle: flush wins and the request is dropped.
- Reset: state IDLE, ready=1, busy=0, done=0, result=0, counter=0, internal accumulators cleared.

## Timing
- Call the cycle in which start is accepted cycle 0.
- Iterative op: CALC occupies cycles 1..XLEN, FIX is cycle XLEN+1, and done is high in cycle XLEN+2 (34 for XLEN=32).
- Special-case divide: done is high in cycle 1.
- ready returns high in the cycle after done. Back-to-back start is accepted in that cycle, giving a throughput of one op per XLEN+3 cycles.
- done is never high for two consecutive cycles.
- result changes only on the edge that raises done.

## Configuration
- MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU skip CALC and FIX. The full signed/unsigned 2·XLEN product is computed combinationally from the latched operands in DONE entry, so done is high in cycle 1. Division is unchanged.
- MULDIV_FAST_MUL_EN undefined: all multiplies use the iterative path, with done in cycle XLEN+2.

## Test plan
- Reset: assert rst for 2 cycles -> ready=1, busy=0, done=0, result=0.
- MULH, op_a=0x80000000, op_b=0x80000000 -> result=0x40000000. MULHSU on the same operands -> 0xC0000000. MUL with op_a=7, op_b=−3 -> 0xFFFFFFEB. done latency is 34 cycles, or 1 with MULDIV_FAST_MUL_EN.
- DIV op_a=−7, op_b=2 -> 0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF; DIVU op_a=100, op_b=7 -> 14; REMU on the same operands -> 2. Each has done in cycle 34.
- Special cases: DIVU x/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/−1 -> 0x80000000; REM 0x80000000/−1 -> 0. All have done in cycle 1.
- flush asserted in cycle 10 of a DIV -> no done pulse, ready=1 in cycle 11, and result keeps its previous value. A start issued at cycle 5 is ignored.
- Run with XLEN=8 across all 8 func3 values and randomised operands against a reference model. Check result, done at cycle 10, and back-to-back starts issued in the cycle ready rises.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU) beside the execute-stage ALU.
// Ports: clk, rst (sync, active-high), start/func3/op_a/op_b request,
//   flush abort, ready/busy status, done pulse with result.
// Option: define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            ready,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        f3_q;
   logic              sgn_a;
   logic              sgn_b;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   res_q;

   // request decode
   logic            is_div;
   logic            signed_a;
   logic            signed_b;
   logic            neg_a_in;
   logic            neg_b_in;
   logic [XLEN-1:0] mag_a_in;
   logic [XLEN-1:0] mag_b_in;
   logic            div_zero;
   logic            ovf;
   logic            special;
   logic [XLEN-1:0] spec_res;
   logic            fast_go;
   logic [XLEN-1:0] fast_res;

   always_comb begin
      is_div   = func3[2];
      signed_a = (func3 == 3'b001) || (func3 == 3'b010) ||
                 (func3 == 3'b100) || (func3 == 3'b110);
      signed_b = (func3 == 3'b001) || (func3 == 3'b100) ||
                 (func3 == 3'b110);
      neg_a_in = signed_a & op_a[XLEN-1];
      neg_b_in = signed_b & op_b[XLEN-1];
      mag_a_in = neg_a_in ? (~op_a + 1'b1) : op_a;
      mag_b_in = neg_b_in ? (~op_b + 1'b1) : op_b;
      div_zero = (op_b == '0);
      ovf      = ((func3 == 3'b100) || (func3 == 3'b110)) &&
                 (op_a == MIN_VAL) && (op_b == '1);
      special  = is_div && (div_zero || ovf);
      // func3[1] separates REM/REMU from DIV/DIVU
      if (div_zero)
         spec_res = func3[1] ? op_a : '1;
      else
         spec_res = func3[1] ? '0 : op_a;
   end

`ifdef MULDIV_FAST_MUL_EN
   // one extra sign bit lets one signed multiplier serve all four forms
   logic signed [XLEN:0]     fa;
   logic signed [XLEN:0]     fb;
   logic signed [2*XLEN+1:0] fp;

   always_comb begin
      fa      = $signed({signed_a & op_a[XLEN-1], op_a});
      fb      = $signed({signed_b & op_b[XLEN-1], op_b});
      fp      = fa * fb;
      fast_go = ~is_div;
      if (func3[1:0] == 2'b00)
         fast_res = fp[XLEN-1:0];
      else
         fast_res = fp[2*XLEN-1:XLEN];
   end
`else
   always_comb begin
      fast_go  = 1'b0;
      fast_res = '0;
   end
`endif

   // one iteration: multiply keeps the multiplier in acc low half,
   // divide keeps {remainder, quotient-in-progress}
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_sh;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] mul_next;
   logic [2*XLEN-1:0] div_next;

   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} +
                 {1'b0, (acc[0] ? mag_a : '0)};
      mul_next = {mul_sum, acc[XLEN-1:1]};
      div_sh   = acc[2*XLEN-1:XLEN-1];
      div_diff = div_sh - {1'b0, mag_b};
      div_next = {(div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0]),
                  acc[XLEN-2:0], ~div_diff[XLEN]};
   end

   // sign correction
   logic              neg_q;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   fix_res;

   always_comb begin
      neg_q = sgn_a ^ sgn_b;
      prod  = neg_q ? (~acc + 1'b1) : acc;
      quo   = neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
      rem   = sgn_a ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
      fix_res = '0;
      unique case (f3_q)
         3'b000:                 fix_res = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fix_res = quo;
         default:                fix_res = rem;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         f3_q  <= '0;
         sgn_a <= 1'b0;
         sgn_b <= 1'b0;
         mag_a <= '0;
         mag_b <= '0;
         acc   <= '0;
         res_q <= '0;
      end else if (flush) begin
         state <= S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  f3_q  <= func3;
                  sgn_a <= neg_a_in;
                  sgn_b <= neg_b_in;
                  mag_a <= mag_a_in;
                  mag_b <= mag_b_in;
                  if (special) begin
                     res_q <= spec_res;
                     state <= S_DONE;
                  end else if (fast_go) begin
                     res_q <= fast_res;
                     state <= S_DONE;
                  end else begin
                     acc   <= {{XLEN{1'b0}}, (is_div ? mag_a_in : mag_b_in)};
                     cnt   <= CNT_W'(XLEN);
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               acc <= f3_q[2] ? div_next : mul_next;
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1))
                  state <= S_FIX;
            end
            S_FIX: begin
               res_q <= fix_res;
               state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ready  = (state == S_IDLE);
   assign busy   = ~ready;
   assign done   = (state == S_DONE);
   assign result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit at XLEN=32 plus
// model-compared back-to-back operations at XLEN=8.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        start32, flush32, ready32, busy32, done32;
   logic [2:0]  f3_32;
   logic [31:0] a32, b32, res32;

   logic        start8, flush8, ready8, busy8, done8;
   logic [2:0]  f3_8;
   logic [7:0]  a8, b8, res8;

   int checks = 0;
   int failures = 0;
   logic [31:0] last32;

   muldiv_unit #(.XLEN(32)) u_dut32 (
      .clk(clk), .rst(rst), .start(start32), .func3(f3_32),
      .op_a(a32), .op_b(b32), .flush(flush32), .ready(ready32),
      .busy(busy32), .done(done32), .result(res32)
   );

   muldiv_unit #(.XLEN(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .func3(f3_8),
      .op_a(a8), .op_b(b8), .flush(flush8), .ready(ready8),
      .busy(busy8), .done(done8), .result(res8)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // entered and left #1 after a rising edge, in a ready cycle
   task automatic op32(input string tag, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
      int n;
      check({tag, "_rdy"}, ready32, 1);
      start32 = 1'b1; f3_32 = f; a32 = a; b32 = b;
      @(posedge clk); #1;
      start32 = 1'b0;
      n = 1;
      while (!done32 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_lat"}, n, lat);
      check({tag, "_res"}, res32, exp);
      last32 = exp;
      @(posedge clk); #1;
      check({tag, "_done_off"}, done32, 0);
      check({tag, "_rdy_back"}, ready32, 1);
   endtask

   task automatic op8(input string tag, input logic [2:0] f,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input int lat);
      int n;
      check({tag, "_rdy"}, ready8, 1);
      start8 = 1'b1; f3_8 = f; a8 = a; b8 = b;
      @(posedge clk); #1;
      start8 = 1'b0;
      n = 1;
      while (!done8 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_lat"}, n, lat);
      check({tag, "_res"}, res8, exp);
      @(posedge clk); #1;
      check({tag, "_done_off"}, done8, 0);
   endtask

   function automatic logic [7:0] ref8(input logic [2:0] f,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
      longint sa, sb, ua, ub, p;
      logic ovf;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      ovf = (a == 8'h80) && (b == 8'hff);
      p = 0;
      case (f)
         3'd0: begin p = sa * sb; return p[7:0]; end
         3'd1: begin p = sa * sb; return p[15:8]; end
         3'd2: begin p = sa * ub; return p[15:8]; end
         3'd3: begin p = ua * ub; return p[15:8]; end
         3'd4: begin
            if (b == 0) return 8'hff;
            if (ovf) return a;
            p = sa / sb; return p[7:0];
         end
         3'd5: begin
            if (b == 0) return 8'hff;
            p = ua / ub; return p[7:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 8'h00;
            p = sa % sb; return p[7:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[7:0];
         end
      endcase
   endfunction

   function automatic int lat8(input logic [2:0] f, input logic [7:0] a,
                               input logic [7:0] b);
      if (f[2] && (b == 0)) return 1;
      if (((f == 3'd4) || (f == 3'd6)) && (a == 8'h80) && (b == 8'hff))
         return 1;
      if (!f[2] && FAST) return 1;
      return 10;
   endfunction

   function automatic logic [7:0] pick8();
      int r;
      r = $urandom_range(0, 5);
      case (r)
         0: return 8'h00;
         1: return 8'h80;
         2: return 8'hff;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      int mlat;
      int n;
      logic seen;
      logic [2:0] f;
      logic [7:0] a, b;

      mlat = FAST ? 1 : 34;
      rst = 1'b1;
      start32 = 0; flush32 = 0; f3_32 = 0; a32 = 0; b32 = 0;
      start8 = 0; flush8 = 0; f3_8 = 0; a8 = 0; b8 = 0;
      last32 = 0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", ready32, 1);
      check("rst_busy", busy32, 0);
      check("rst_done", done32, 0);
      check("rst_result", res32, 0);
      check("rst_result8", res8, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      op32("mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, mlat);
      op32("mulhsu", 3'b010, 32'h80000000, 32'h80000000, 32'hC0000000, mlat);
      op32("mulhu", 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, mlat);
      op32("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, mlat);
      op32("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
      op32("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
      op32("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34);
      op32("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);
      op32("divu_z", 3'b101, 32'd1234, 32'd0, 32'hFFFFFFFF, 1);
      op32("div_z", 3'b100, 32'd1234, 32'd0, 32'hFFFFFFFF, 1);
      op32("rem_z", 3'b110, 32'd5, 32'd0, 32'd5, 1);
      op32("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      op32("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
      op32("remu_last", 3'b111, 32'd50, 32'd8, 32'd2, 34);

      // flush mid-divide; stray start at cycle 5 must be ignored
      seen = 1'b0;
      start32 = 1'b1; f3_32 = 3'b100; a32 = 32'd1000; b32 = 32'd3;
      @(posedge clk); #1;
      for (n = 1; n < 10; n++) begin
         start32 = (n == 5);
         if (n == 5) begin
            f3_32 = 3'b101; a32 = 32'd9; b32 = 32'd0;
         end
         if (n == 1) check("fl_busy", busy32, 1);
         if (done32) seen = 1'b1;
         @(posedge clk); #1;
      end
      start32 = 1'b0;
      flush32 = 1'b1;
      if (done32) seen = 1'b1;
      @(posedge clk); #1;
      flush32 = 1'b0;
      check("fl_ready11", ready32, 1);
      check("fl_busy11", busy32, 0);
      check("fl_result", res32, last32);
      for (n = 0; n < 40; n++) begin
         if (done32) seen = 1'b1;
         @(posedge clk); #1;
      end
      check("fl_no_done", seen, 0);
      check("fl_result_hold", res32, last32);

      // XLEN=8: every func3, mixed edge/random operands, back-to-back
      for (int i = 0; i < 64; i++) begin
         f = 3'(i % 8);
         a = pick8();
         b = pick8();
         op8($sformatf("x8_%0d_f%0d_%02h_%02h", i, f, a, b),
             f, a, b, ref8(f, a, b), lat8(f, a, b));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
